bank_to_sfu: RTL

//  Read-back engine for the psum bank: after a start pulse, streams len_onij psum words (addr 0..len_onij-1)
//  out of the single-port psum SRAM into the SFU. Pairs with the SFU->bank write path for partial-sum

---
 rtl/bank_to_sfu_if.sv | 24 ++
 rtl/bank_to_sfu.sv | 107 ++++++++++
 2 files changed

// File: rtl/bank_to_sfu_if.sv
// Bank read port plus SFU stream for the psum read-back engine.
// The master side is the engine; the slave side is the SRAM/SFU.
interface bank_to_sfu_if #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int AW      = 4
) ();
  logic                   bank_rd_en_o;
  logic [AW-1:0]          bank_addr_o;
  logic [col*psum_bw-1:0] bank_rdata_i;
  logic [col*psum_bw-1:0] psum_data_o;
  logic                   psum_data_out_valid;
  logic                   sfu_ready_i;

  modport master (
    output bank_rd_en_o, bank_addr_o, psum_data_o, psum_data_out_valid,
    input  bank_rdata_i, sfu_ready_i
  );

  modport slave (
    input  bank_rd_en_o, bank_addr_o, psum_data_o, psum_data_out_valid,
    output bank_rdata_i, sfu_ready_i
  );
endinterface

// File: rtl/bank_to_sfu.sv
// Psum bank read-back engine: streams len_onij words from the psum SRAM to the SFU,
// absorbing the 1-cycle SRAM latency and SFU backpressure with a 2-entry FIFO.
module bank_to_sfu #(
  parameter int psum_bw  = 16,
  parameter int col      = 8,
  parameter int len_onij = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  bank_to_sfu_if.master bif,
  output logic          busy_o,
  output logic          readback_done_o
);
  localparam int AW = $clog2(len_onij);
  localparam int W  = col * psum_bw;
  localparam logic [AW:0] LEN = (AW+1)'(len_onij);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e         state_q, state_d;
  logic [AW:0]    issued_q, issued_d;
  logic           inflight_q, inflight_d;
  logic [1:0]     count_q, count_d;
  logic [W-1:0]   buf0_q, buf0_d, buf1_q, buf1_d;
  logic           busy_q, done_q;
  logic           rd_en, pop, push, drained;

  always_comb begin
    pop   = (count_q != 2'd0) && bif.sfu_ready_i;
    push  = inflight_q;
    // Issue only when the slot a returning word will need is guaranteed free.
    rd_en = (state_q == READ) && (issued_q < LEN) &&
            ((({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2) || pop);

    issued_d   = rd_en ? issued_q + 1'b1 : issued_q;
    inflight_d = rd_en;
    if (state_q == DONE) issued_d = '0;

    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) buf0_d = bif.bank_rdata_i;
        else                 buf1_d = bif.bank_rdata_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        buf0_d  = buf1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          buf0_d = buf1_q;
          buf1_d = bif.bank_rdata_i;
        end else begin
          buf0_d = bif.bank_rdata_i;
        end
      end
      default: ;
    endcase

    drained = (count_d == 2'd0) && !inflight_d;

    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i) state_d = READ;
      READ:  if (issued_d == LEN) state_d = drained ? DONE : DRAIN;
      DRAIN: if (drained) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      buf0_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      buf0_q     <= buf0_d;
      busy_q     <= (state_d == READ) || (state_d == DRAIN);
      done_q     <= (state_d == DONE);
    end
  end

  // Second slot carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    buf1_q <= buf1_d;
  end

  assign bif.bank_rd_en_o        = rd_en;
  assign bif.bank_addr_o         = issued_q[AW-1:0];
  assign bif.psum_data_o         = buf0_q;
  assign bif.psum_data_out_valid = (count_q != 2'd0);
  assign busy_o                  = busy_q;
  assign readback_done_o         = done_q;
endmodule
